full_adder_reg: RTL and testbench

- Registered full adder with a configurable width; at the default width of 1 it is a single-bit full adder.
- Computes S = A + B + Cin and a carry-out Cout, presented one clock after the inputs are accepted.
- Used as an arithmetic leaf cell; wider instances form a ripple-carry adder built from 1-bit full-adder cells.

---
 rtl/fa_cell.sv | 16 +
 rtl/full_adder_reg.sv | 67 ++++++
 tb/tb_full_adder_reg.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - 1-bit combinational full adder cell
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum is the parity of the three inputs.
  assign s  = a ^ b ^ ci;

  // Carry-out is the majority of the three inputs.
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder_reg.sv
// rtl/full_adder_reg.sv - registered ripple-carry full adder, one-cycle latency
module full_adder_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_valid
);

  // carry[i] enters bit i; carry[WIDTH] leaves the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  assign carry[0] = Cin;

  // Ripple chain of 1-bit cells from bit 0 up to the MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_fa_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Next state: load a new result when the inputs are qualified, otherwise
  // hold; the inputs are ignored entirely when in_valid is low so unknown
  // values on idle cycles cannot leak into the registers.
  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      s_d    = sum;
      cout_d = carry[WIDTH];
    end
  end

  // Output registers with synchronous reset taking priority over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign S         = s_q;
  assign Cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder_reg.sv
// tb/tb_full_adder_reg.sv - self-checking bench for full_adder_reg at widths 1 and 8
module tb_full_adder_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v1, a1, b1, c1;
  logic       s1, co1, ov1;
  logic       v8, c8;
  logic [7:0] a8, b8;
  logic [7:0] s8;
  logic       co8, ov8;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: what each instance must present after the latest edge.
  logic       m1_s, m1_c, m1_v;
  logic [7:0] m8_s;
  logic       m8_c, m8_v;

  full_adder_reg #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .A         (a1),
    .B         (b1),
    .Cin       (c1),
    .S         (s1),
    .Cout      (co1),
    .out_valid (ov1)
  );

  full_adder_reg #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v8),
    .A         (a8),
    .B         (b8),
    .Cin       (c8),
    .S         (s8),
    .Cout      (co8),
    .out_valid (ov8)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // One clock edge: update the reference from the values the DUTs see,
  // then compare every output shortly after the edge.
  task automatic cycle(input string tag);
    int t;
    @(posedge clk);
    if (rst) begin
      m1_s = 1'b0; m1_c = 1'b0; m1_v = 1'b0;
      m8_s = 8'h00; m8_c = 1'b0; m8_v = 1'b0;
    end else begin
      if (v1) begin
        t = int'(a1) + int'(b1) + int'(c1);
        m1_s = t[0]; m1_c = t[1]; m1_v = 1'b1;
      end else begin
        m1_v = 1'b0;
      end
      if (v8) begin
        t = int'(a8) + int'(b8) + int'(c8);
        m8_s = t[7:0]; m8_c = t[8]; m8_v = 1'b1;
      end else begin
        m8_v = 1'b0;
      end
    end
    #1;
    chk1({tag, ".w1.S"},    s1,  m1_s);
    chk1({tag, ".w1.Cout"}, co1, m1_c);
    chk1({tag, ".w1.ov"},   ov1, m1_v);
    chk8({tag, ".w8.S"},    s8,  m8_s);
    chk1({tag, ".w8.Cout"}, co8, m8_c);
    chk1({tag, ".w8.ov"},   ov8, m8_v);
  endtask

  initial begin
    // Reset held for two edges with live inputs that must be ignored.
    rst = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b1;
    cycle("reset0");
    cycle("reset1");
    rst = 1'b0; v1 = 1'b0; v8 = 1'b0;
    cycle("reset_release");
    chk1("reset_release.S_zero", s1, 1'b0);
    chk8("reset_release.S8_zero", s8, 8'h00);

    // Full 1-bit truth table, back-to-back; the wide instance adds the same bits.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      v1 = 1'b1; {a1, b1, c1} = abc;
      v8 = 1'b1; a8 = {7'd0, abc[2]}; b8 = {7'd0, abc[1]}; c8 = abc[0];
      cycle($sformatf("tt%0d", i));
      chk1($sformatf("tt%0d.S_const", i), s1, abc[2] ^ abc[1] ^ abc[0]);
      chk1($sformatf("tt%0d.C_const", i), co1, (abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0]));
    end

    // Hold: result stays while an idle cycle carries different inputs.
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    v8 = 1'b1; a8 = 8'h01; b8 = 8'h00; c8 = 1'b0;
    cycle("hold_load");
    v1 = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    cycle("hold_idle");
    chk1("hold_idle.S_const", s1, 1'b1);
    chk1("hold_idle.C_const", co1, 1'b0);
    chk1("hold_idle.ov_const", ov1, 1'b0);

    // Full-length carry ripple on the wide instance.
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
    cycle("ripple_ff00");
    chk8("ripple_ff00.S_const", s8, 8'h00);
    chk1("ripple_ff00.C_const", co8, 1'b1);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    cycle("ripple_ffff");
    chk8("ripple_ffff.S_const", s8, 8'hFF);
    chk1("ripple_ffff.C_const", co8, 1'b1);

    // Transaction coinciding with reset is dropped and never surfaces.
    rst = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    v8 = 1'b1; a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    cycle("midrst");
    rst = 1'b0; v1 = 1'b0; v8 = 1'b0;
    a1 = 1'bx; b1 = 1'bx; c1 = 1'bx; a8 = 'x; b8 = 'x; c8 = 1'bx;
    for (int i = 0; i < 3; i++) cycle($sformatf("midrst_after%0d", i));

    // Random traffic: idle cycles drive unknowns, occasional resets.
    for (int i = 0; i < 60; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      v1  = ($urandom_range(0, 3) != 0);
      v8  = ($urandom_range(0, 3) != 0);
      if (v1) begin
        a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      end else begin
        a1 = 1'bx; b1 = 1'bx; c1 = 1'bx;
      end
      if (v8) begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      end else begin
        a8 = 'x; b8 = 'x; c8 = 1'bx;
      end
      cycle($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
